book_update_ctrl: RTL and testbench
===================================

// Module: book_update_ctrl
// PURPOSE
// Sequences normalized depth events (post-parser, price already mapped to a tick index) into a
// single-port BRAM level table holding quantity per {side, price_idx}. Each event is a
// read-modify-write on the table. The block also checks update_id ordering, maintains per-side
// active-level counts, emits old/new qty per level change, and arbitrates table clears
// against the live event stream.
// PARAMETERS
// INDEX_W  10  price-index width; table depth = 2**(INDEX_W+1) (bid half, ask half)
// QTY_W    32  quantity word width (f32 bit pattern or fixed-point, opaque here)
// UID_W    64  update_id width
// PORTS
// clk            in   1        system clock
// rst_n          in   1        synchronous active-low reset
// in_valid       in   1        depth event valid
// in_ready       out  1        event accept
// in_side        in   1        0=bid 1=ask
// in_price_idx   in   INDEX_W  price tick index
// in_qty         in   QTY_W    new level qty (0 = delete level)
// in_update_id   in   UID_W    exchange update_id
// clear_req      in   1        1-cycle pulse: zero whole table
// clear_done     out  1        1-cycle pulse when clear completes
// mem_en         out  1        table port enable
// mem_we         out  1        table write enable
// mem_addr       out  INDEX_W+1  {side, price_idx}
// mem_wdata      out  QTY_W    write data
// mem_rdata      in   QTY_W    read data, valid 1 cycle after mem_en & !mem_we
// out_valid      out  1        level-change record valid (held until out_ready)
// out_ready      in   1        downstream accept
// out_side/out_price_idx/out_old_qty/out_new_qty/out_update_id  out  as inputs  change record
// bid_levels     out  INDEX_W+1  count of nonzero bid levels
// ask_levels     out  INDEX_W+1  count of nonzero ask levels
// stale_cnt      out  32       events dropped as stale (wraps)
// gap_cnt        out  32       sequence gaps detected (wraps)
// gap_pulse      out  1        1-cycle pulse on gap
// BEHAVIOUR
// - Reset: state IDLE, in_ready=0 in the reset cycle, all other outputs, counts, flags,
//   seen_any and clear_pending = 0. Table contents are NOT touched; software issues clear_req.
// - FSM states: IDLE, RD, WR, OUT, CLR.
//   - IDLE: in_ready = !clear_pending && !clear_req.
//     - clear_req or clear_pending -> CLR. Clear wins over a simultaneous in_valid.
//     - Otherwise, an in_valid&&in_ready handshake latches the event.
//       - If seen_any && uid <= last_uid: drop, stale_cnt++, stay IDLE, no memory access.
//       - Otherwise: if seen_any && uid != last_uid+1, then gap_pulse=1 and gap_cnt++, and the
//         event is still applied. Set last_uid=uid, seen_any=1, go to RD.
//   - RD: mem_en=1, mem_we=0, mem_addr = latched address. Go to WR.
//   - WR: old=mem_rdata. mem_en=1, mem_we=1, mem_wdata=new qty. Load output regs.
//     Level-count update on that side: old==0 && new!=0 -> +1; old!=0 && new==0 -> -1; else
//     hold. Go to OUT.
//   - OUT: out_valid=1, fields stable until out_ready. On handshake go to IDLE.
//     A record with old==new is still emitted.
//   - CLR: write 0 to addr 0..2**(INDEX_W+1)-1, one per cycle (mem_en=mem_we=1). After the
//     last write: clear_done pulse, bid/ask_levels=0, seen_any=0, clear_pending=0, go to IDLE.
// - clear_req outside IDLE sets clear_pending. It is serviced on the next IDLE entry, after
//   the in-flight event completes, including its OUT handshake. Further pulses merge.
// - Latency: accept at cycle T; read issued T+1; write issued T+2; out_valid from T+3.
//   in_ready returns the cycle after the out handshake. Peak rate is 1 event per 4 cycles.
// - last_uid+1 is computed at UID_W bits. all-ones followed by 0 is treated as stale
//   (no wrap support).
// - mem_en=0 in IDLE and OUT. Exactly one port access per RD/WR/CLR cycle.
// STRUCTURE
// - book_ctrl_pkg: state enum book_ctrl_state_t, SIDE_BID/SIDE_ASK constants, and
//   level_change_t struct (side, price_idx, old_qty, new_qty, update_id).
//   Width parameters are mirrored as package localparams.
// - Sub-module uid_seq_check: seen_any/last_uid registers and stale/gap decision
//   (combinational decision, registered state).
// - The table BRAM is external; this block only drives the port.
// TESTING
// - Reset then event bid idx 5 qty 0x10 uid 100 -> RD/WR at addr 0x005, out old=0 new=0x10,
//   bid_levels=1, gap_cnt=0.
// - Then ask idx 5 qty 0x20 uid 101, then ask idx 5 qty 0 uid 102 -> writes at addr 0x405;
//   ask_levels goes 1 then 0; second record old=0x20 new=0.
// - After uid 102, send uid 102, then uid 50 -> both dropped, stale_cnt=2, no mem_en, in_ready
//   stays 1.
// - After uid 102, send uid 110 -> gap_pulse once, gap_cnt=1; update applied and emitted.
// - Hold out_ready=0 for 20 cycles -> out_valid and fields stable, in_ready=0. Then release ->
//   single handshake.
// - clear_req during RD -> event completes first, then 2048 zero writes, clear_done, levels=0.
//   Next event uid 5 is accepted with no stale or gap.
// - rst_n low for one cycle while in WR -> next cycle IDLE, out_valid=0, all counters=0.

Source files
------------

// File: rtl/book_update_ctrl_pkg.sv
// Shared types and default widths for the order-book level-table controller.
package book_ctrl_pkg;

  localparam int BOOK_INDEX_W = 10;
  localparam int BOOK_QTY_W   = 32;
  localparam int BOOK_UID_W   = 64;

  localparam logic SIDE_BID = 1'b0;
  localparam logic SIDE_ASK = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_OUT,
    S_CLR
  } book_ctrl_state_t;

  typedef struct packed {
    logic                    side;
    logic [BOOK_INDEX_W-1:0] price_idx;
    logic [BOOK_QTY_W-1:0]   old_qty;
    logic [BOOK_QTY_W-1:0]   new_qty;
    logic [BOOK_UID_W-1:0]   update_id;
  } level_change_t;

endpackage

// File: rtl/book_update_ctrl_if.sv
// Event-in and level-change-out streams of the book update controller.
interface book_update_ctrl_if #(
  parameter int INDEX_W = 10,
  parameter int QTY_W   = 32,
  parameter int UID_W   = 64
);
  logic               in_valid;
  logic               in_ready;
  logic               in_side;
  logic [INDEX_W-1:0] in_price_idx;
  logic [QTY_W-1:0]   in_qty;
  logic [UID_W-1:0]   in_update_id;

  logic               out_valid;
  logic               out_ready;
  logic               out_side;
  logic [INDEX_W-1:0] out_price_idx;
  logic [QTY_W-1:0]   out_old_qty;
  logic [QTY_W-1:0]   out_new_qty;
  logic [UID_W-1:0]   out_update_id;

  // Controller side
  modport slave (
    input  in_valid, in_side, in_price_idx, in_qty, in_update_id,
    output in_ready,
    output out_valid, out_side, out_price_idx, out_old_qty, out_new_qty, out_update_id,
    input  out_ready
  );

  // Event source / record consumer side
  modport master (
    output in_valid, in_side, in_price_idx, in_qty, in_update_id,
    input  in_ready,
    input  out_valid, out_side, out_price_idx, out_old_qty, out_new_qty, out_update_id,
    output out_ready
  );
endinterface

// File: rtl/book_update_ctrl_uid_seq_check.sv
// update_id ordering tracker: remembers the last applied id and classifies
// an incoming id as stale (drop) or gapped (apply, but flag).
module uid_seq_check #(
  parameter int UID_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [UID_W-1:0] uid,
  input  logic             commit,
  input  logic             clear,
  output logic             stale,
  output logic             gap
);
  localparam logic [UID_W-1:0] UID_ONE = {{(UID_W-1){1'b0}}, 1'b1};

  logic             seen_any;
  logic [UID_W-1:0] last_uid;

  // No wrap support: all-ones followed by zero falls into the stale branch.
  assign stale = seen_any && (uid <= last_uid);
  assign gap   = seen_any && !stale && (uid != last_uid + UID_ONE);

  // Track the most recent applied id; a table clear forgets the history.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_any <= 1'b0;
      last_uid <= '0;
    end else if (clear) begin
      seen_any <= 1'b0;
    end else if (commit) begin
      seen_any <= 1'b1;
      last_uid <= uid;
    end
  end
endmodule

// File: rtl/book_update_ctrl.sv
// Read-modify-write sequencer for the {side, price_idx} quantity table,
// with per-side active-level counts and a table-clear engine.
//
// state  | meaning
// IDLE   | waiting for an event or a clear; no table access
// RD     | table read of the latched address
// WR     | capture old qty, write new qty, update level count
// OUT    | change record held until out_ready
// CLR    | zero the whole table, one address per cycle
module book_update_ctrl
  import book_ctrl_pkg::*;
#(
  parameter int INDEX_W = BOOK_INDEX_W,
  parameter int QTY_W   = BOOK_QTY_W,
  parameter int UID_W   = BOOK_UID_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  book_update_ctrl_if.slave    bus,
  input  logic                 clear_req,
  output logic                 clear_done,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [INDEX_W:0]     mem_addr,
  output logic [QTY_W-1:0]     mem_wdata,
  input  logic [QTY_W-1:0]     mem_rdata,
  output logic [INDEX_W:0]     bid_levels,
  output logic [INDEX_W:0]     ask_levels,
  output logic [31:0]          stale_cnt,
  output logic [31:0]          gap_cnt,
  output logic                 gap_pulse
);
  localparam logic [INDEX_W:0] LVL_ONE = {{INDEX_W{1'b0}}, 1'b1};

  book_ctrl_state_t   state;
  logic               clear_pending;
  logic               in_ready;
  logic               stale;
  logic               gap;
  logic               commit;
  logic               seq_clear;
  logic               out_valid;
  logic               ev_side;
  logic [INDEX_W-1:0] ev_idx;
  logic [QTY_W-1:0]   ev_qty;
  logic [UID_W-1:0]   ev_uid;
  logic [QTY_W-1:0]   old_qty;

  // A pending or arriving clear blocks new events so it wins any tie.
  assign in_ready  = rst_n && (state == S_IDLE) && !clear_pending && !clear_req;
  assign commit    = bus.in_valid && in_ready && !stale;
  assign seq_clear = (state == S_CLR) && (mem_addr == '1);

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid;
  assign bus.out_side      = ev_side;
  assign bus.out_price_idx = ev_idx;
  assign bus.out_old_qty   = old_qty;
  assign bus.out_new_qty   = ev_qty;
  assign bus.out_update_id = ev_uid;

  uid_seq_check #(.UID_W(UID_W)) u_seq (
    .clk    (clk),
    .rst_n  (rst_n),
    .uid    (bus.in_update_id),
    .commit (commit),
    .clear  (seq_clear),
    .stale  (stale),
    .gap    (gap)
  );

  // Main sequencer; table port and record outputs are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      clear_pending <= 1'b0;
      clear_done    <= 1'b0;
      gap_pulse     <= 1'b0;
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      out_valid     <= 1'b0;
      ev_side       <= 1'b0;
      ev_idx        <= '0;
      ev_qty        <= '0;
      ev_uid        <= '0;
      old_qty       <= '0;
      bid_levels    <= '0;
      ask_levels    <= '0;
      stale_cnt     <= '0;
      gap_cnt       <= '0;
    end else begin
      clear_done <= 1'b0;
      gap_pulse  <= 1'b0;
      if (clear_req && state != S_IDLE) clear_pending <= 1'b1;

      case (state)
        S_IDLE: begin
          if (clear_req || clear_pending) begin
            state     <= S_CLR;
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= '0;
            mem_wdata <= '0;
          end else if (bus.in_valid) begin
            if (stale) begin
              stale_cnt <= stale_cnt + 32'd1;
            end else begin
              if (gap) begin
                gap_pulse <= 1'b1;
                gap_cnt   <= gap_cnt + 32'd1;
              end
              ev_side  <= bus.in_side;
              ev_idx   <= bus.in_price_idx;
              ev_qty   <= bus.in_qty;
              ev_uid   <= bus.in_update_id;
              mem_en   <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {bus.in_side, bus.in_price_idx};
              state    <= S_RD;
            end
          end
        end
        S_RD: begin
          mem_we    <= 1'b1;
          mem_wdata <= ev_qty;
          state     <= S_WR;
        end
        S_WR: begin
          mem_en    <= 1'b0;
          mem_we    <= 1'b0;
          old_qty   <= mem_rdata;
          out_valid <= 1'b1;
          if (mem_rdata == '0 && ev_qty != '0) begin
            if (ev_side == SIDE_ASK) ask_levels <= ask_levels + LVL_ONE;
            else                     bid_levels <= bid_levels + LVL_ONE;
          end else if (mem_rdata != '0 && ev_qty == '0) begin
            if (ev_side == SIDE_ASK) ask_levels <= ask_levels - LVL_ONE;
            else                     bid_levels <= bid_levels - LVL_ONE;
          end
          state <= S_OUT;
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        S_CLR: begin
          if (mem_addr == '1) begin
            mem_en        <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            clear_done    <= 1'b1;
            bid_levels    <= '0;
            ask_levels    <= '0;
            clear_pending <= 1'b0;
            state         <= S_IDLE;
          end else begin
            mem_addr <= mem_addr + LVL_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_book_update_ctrl.sv
// Self-checking bench for book_update_ctrl with a behavioural book model.
module tb_book_update_ctrl;
  import book_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_req = 1'b0;
  logic        clear_done;
  logic        mem_en, mem_we;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [10:0] bid_levels, ask_levels;
  logic [31:0] stale_cnt, gap_cnt;
  logic        gap_pulse;

  book_update_ctrl_if #(.INDEX_W(10), .QTY_W(32), .UID_W(64)) bus ();

  book_update_ctrl dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .clear_req(clear_req), .clear_done(clear_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .bid_levels(bid_levels), .ask_levels(ask_levels),
    .stale_cnt(stale_cnt), .gap_cnt(gap_cnt), .gap_pulse(gap_pulse)
  );

  always #5 clk = ~clk;

  // Behavioural single-port BRAM plus access counters
  logic [31:0] tb_mem [0:2047];
  logic        fill_en = 1'b1;
  int          en_cnt = 0, wr_cnt = 0, zero_wr_cnt = 0;
  always @(posedge clk) begin
    if (fill_en) begin
      for (int i = 0; i < 2048; i++) tb_mem[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (mem_en) begin
      en_cnt <= en_cnt + 1;
      if (mem_we) begin
        tb_mem[mem_addr] <= mem_wdata;
        wr_cnt <= wr_cnt + 1;
        if (mem_wdata == 32'd0) zero_wr_cnt <= zero_wr_cnt + 1;
      end else begin
        mem_rdata <= tb_mem[mem_addr];
      end
    end
  end

  // Reference model of the book
  logic [31:0] m_tbl [0:2047];
  bit          m_seen = 0;
  logic [63:0] m_last = '0;
  int          m_stale = 0, m_gap = 0;
  int          n_checks = 0, n_fail = 0;

  function automatic int count_lv(input logic s);
    int c = 0;
    for (int i = 0; i < 1024; i++) if (m_tbl[{s, i[9:0]}] != 32'd0) c++;
    return c;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    fill_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    n_checks++; if ({bus.out_valid, mem_en, mem_we, clear_done, gap_pulse} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got %b want 00000", {bus.out_valid, mem_en, mem_we, clear_done, gap_pulse}); end
    n_checks++; if ({stale_cnt, gap_cnt, bid_levels, ask_levels} !== '0) begin n_fail++; $display("FAIL reset_counts stale=%0d gap=%0d bid=%0d ask=%0d want 0", stale_cnt, gap_cnt, bid_levels, ask_levels); end
    rst_n = 1'b1;
    fill_en = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic finish_clear(input string tag);
    int n = 0, nz = 0, w0, z0;
    w0 = wr_cnt; z0 = zero_wr_cnt;
    while (clear_done !== 1'b1 && n < 3000) begin @(posedge clk); #1; n++; end
    n_checks++; if (clear_done !== 1'b1) begin n_fail++; $display("FAIL %s clear_done_timeout got %b want 1", tag, clear_done); end
    n_checks++; if ((wr_cnt - w0) != 2048 || (zero_wr_cnt - z0) != 2048) begin n_fail++; $display("FAIL %s clear_writes got %0d/%0d zero want 2048", tag, wr_cnt - w0, zero_wr_cnt - z0); end
    n_checks++; if ({bid_levels, ask_levels, mem_en} !== '0) begin n_fail++; $display("FAIL %s clear_levels bid=%0d ask=%0d en=%b want 0", tag, bid_levels, ask_levels, mem_en); end
    @(posedge clk); #1;
    n_checks++; if (clear_done !== 1'b0) begin n_fail++; $display("FAIL %s clear_done_width got %b want 0", tag, clear_done); end
    for (int i = 0; i < 2048; i++) if (tb_mem[i] != 32'd0) nz++;
    n_checks++; if (nz != 0) begin n_fail++; $display("FAIL %s table_zero got %0d nonzero want 0", tag, nz); end
    for (int i = 0; i < 2048; i++) m_tbl[i] = 32'd0;
    m_seen = 0;
  endtask

  task automatic test_clear();
    @(posedge clk); #1;
    clear_req = 1'b1;
    bus.in_valid = 1'b1; bus.in_side = 1'b0; bus.in_price_idx = 10'd1;
    bus.in_qty = 32'h99; bus.in_update_id = 64'd999;
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL clear_vs_event in_ready got %b want 0", bus.in_ready); end
    @(posedge clk); #1;
    clear_req = 1'b0;
    bus.in_valid = 1'b0;
    finish_clear("init");
  endtask

  task automatic do_event(input logic s, input logic [9:0] idx, input logic [31:0] q,
                          input logic [63:0] u, input int hold, input bit clr_at_rd);
    bit          exp_stale, exp_gap;
    logic [10:0] a;
    logic [31:0] exp_old;
    int          n, en0;
    a = {s, idx};
    exp_stale = m_seen && (u <= m_last);
    exp_gap   = m_seen && !exp_stale && (u != m_last + 64'd1);
    exp_old   = m_tbl[a];
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_timeout uid=%0d got %b want 1", u, bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_side = s; bus.in_price_idx = idx;
    bus.in_qty = q; bus.in_update_id = u;
    bus.out_ready = (hold == 0);
    en0 = en_cnt;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    if (exp_stale) begin
      m_stale++;
      n_checks++; if ({bus.in_ready, mem_en, gap_pulse} !== 3'b100) begin n_fail++; $display("FAIL stale_idle uid=%0d ready/en/gap got %b want 100", u, {bus.in_ready, mem_en, gap_pulse}); end
      n_checks++; if (stale_cnt !== 32'(m_stale)) begin n_fail++; $display("FAIL stale_cnt uid=%0d got %0d want %0d", u, stale_cnt, m_stale); end
      @(posedge clk); #1;
      n_checks++; if (en_cnt != en0) begin n_fail++; $display("FAIL stale_no_access uid=%0d got %0d accesses want 0", u, en_cnt - en0); end
    end else begin
      if (exp_gap) m_gap++;
      m_seen = 1; m_last = u; m_tbl[a] = q;
      if (clr_at_rd) clear_req = 1'b1;
      n_checks++; if (gap_pulse !== exp_gap || gap_cnt !== 32'(m_gap)) begin n_fail++; $display("FAIL gap uid=%0d pulse=%b cnt=%0d want %b/%0d", u, gap_pulse, gap_cnt, exp_gap, m_gap); end
      n_checks++; if ({mem_en, mem_we, mem_addr, bus.in_ready} !== {2'b10, a, 1'b0}) begin n_fail++; $display("FAIL rd_phase uid=%0d en/we=%b%b addr=%h ready=%b want 10 %h 0", u, mem_en, mem_we, mem_addr, bus.in_ready, a); end
      @(posedge clk); #1;
      clear_req = 1'b0;
      n_checks++; if ({mem_en, mem_we, mem_addr, mem_wdata, gap_pulse} !== {2'b11, a, q, 1'b0}) begin n_fail++; $display("FAIL wr_phase uid=%0d en/we=%b%b addr=%h data=%h gap=%b want 11 %h %h 0", u, mem_en, mem_we, mem_addr, mem_wdata, gap_pulse, a, q); end
      @(posedge clk); #1;
      n_checks++; if ({bus.out_valid, bus.out_side, bus.out_price_idx, bus.out_old_qty, bus.out_new_qty, bus.out_update_id, mem_en} !== {1'b1, s, idx, exp_old, q, u, 1'b0}) begin n_fail++; $display("FAIL record uid=%0d v=%b side=%b idx=%0d old=%h new=%h uid=%0d want 1 %b %0d %h %h %0d", u, bus.out_valid, bus.out_side, bus.out_price_idx, bus.out_old_qty, bus.out_new_qty, bus.out_update_id, s, idx, exp_old, q, u); end
      n_checks++; if (int'(bid_levels) != count_lv(1'b0) || int'(ask_levels) != count_lv(1'b1)) begin n_fail++; $display("FAIL levels uid=%0d bid=%0d ask=%0d want %0d/%0d", u, bid_levels, ask_levels, count_lv(1'b0), count_lv(1'b1)); end
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        n_checks++; if ({bus.out_valid, bus.out_old_qty, bus.out_new_qty, bus.out_update_id, bus.in_ready} !== {1'b1, exp_old, q, u, 1'b0}) begin n_fail++; $display("FAIL hold uid=%0d cyc=%0d v=%b old=%h new=%h ready=%b want 1 %h %h 0", u, i, bus.out_valid, bus.out_old_qty, bus.out_new_qty, bus.in_ready, exp_old, q); end
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      n_checks++; if ({bus.out_valid, bus.in_ready} !== {1'b0, !clr_at_rd}) begin n_fail++; $display("FAIL handshake uid=%0d valid/ready got %b%b want 0%b", u, bus.out_valid, bus.in_ready, !clr_at_rd); end
    end
  endtask

  task automatic test_directed();
    do_event(SIDE_BID, 10'd5, 32'h10, 64'd100, 0, 1'b0);
    do_event(SIDE_ASK, 10'd5, 32'h20, 64'd101, 0, 1'b0);
    do_event(SIDE_ASK, 10'd5, 32'h0,  64'd102, 0, 1'b0);
  endtask

  task automatic test_stale();
    do_event(SIDE_BID, 10'd6, 32'h33, 64'd102, 0, 1'b0);
    do_event(SIDE_BID, 10'd6, 32'h33, 64'd50,  0, 1'b0);
  endtask

  task automatic test_gap();
    do_event(SIDE_BID, 10'd8, 32'h44, 64'd110, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    do_event(SIDE_ASK, 10'd9, 32'h55, 64'd111, 20, 1'b0);
  endtask

  task automatic test_random();
    logic [63:0] u;
    int r;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) u = m_last - 64'($urandom_range(0, 3));
      else if (r < 3) u = m_last + 64'($urandom_range(2, 6));
      else u = m_last + 64'd1;
      do_event(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)),
               ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom, u,
               $urandom_range(0, 3), 1'b0);
    end
  endtask

  task automatic test_clear_during_rd();
    do_event(SIDE_BID, 10'd12, 32'h66, m_last + 64'd1, 0, 1'b1);
    finish_clear("rd");
    do_event(SIDE_BID, 10'd3, 32'h77, 64'd5, 0, 1'b0);
    n_checks++; if (stale_cnt !== 32'(m_stale) || gap_cnt !== 32'(m_gap)) begin n_fail++; $display("FAIL post_clear_seq stale=%0d gap=%0d want %0d/%0d", stale_cnt, gap_cnt, m_stale, m_gap); end
  endtask

  task automatic test_reset_in_wr();
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    bus.in_valid = 1'b1; bus.in_side = SIDE_BID; bus.in_price_idx = 10'd9;
    bus.in_qty = 32'h88; bus.in_update_id = m_last + 64'd1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({mem_en, mem_we} !== 2'b11) begin n_fail++; $display("FAIL rst_wr_reach en/we got %b%b want 11", mem_en, mem_we); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_checks++; if ({bus.out_valid, mem_en, gap_pulse, bus.in_ready} !== 4'b0001) begin n_fail++; $display("FAIL rst_wr_state valid/en/gap/ready got %b want 0001", {bus.out_valid, mem_en, gap_pulse, bus.in_ready}); end
    n_checks++; if ({stale_cnt, gap_cnt, bid_levels, ask_levels} !== '0) begin n_fail++; $display("FAIL rst_wr_counts stale=%0d gap=%0d bid=%0d ask=%0d want 0", stale_cnt, gap_cnt, bid_levels, ask_levels); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_side = 1'b0; bus.in_price_idx = '0;
    bus.in_qty = '0; bus.in_update_id = '0; bus.out_ready = 1'b1;
    for (int i = 0; i < 2048; i++) m_tbl[i] = 32'd0;
    test_reset();
    test_clear();
    test_directed();
    test_stale();
    test_gap();
    test_backpressure();
    test_random();
    test_clear_during_rd();
    test_reset_in_wr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1);
  end
endmodule
